// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: button pulses, test-value load and display/status outputs
// between the stopwatch controller and its surroundings.
// master drives buttons and the load strobe; slave is the controller itself.
interface stopwatch_ctrl_if;
  logic        btn_start_stop;
  logic        btn_clear;
  logic        btn_lap;
  logic [31:0] test_value;
  logic        latch_test_value;
  logic [31:0] elapsed;
  logic [31:0] display_value;
  logic        running;
  logic        tick;
  logic        overflow;
  logic        lap_active;

  modport master (
    output btn_start_stop,
    output btn_clear,
    output btn_lap,
    output test_value,
    output latch_test_value,
    input  elapsed,
    input  display_value,
    input  running,
    input  tick,
    input  overflow,
    input  lap_active
  );

  modport slave (
    input  btn_start_stop,
    input  btn_clear,
    input  btn_lap,
    input  test_value,
    input  latch_test_value,
    output elapsed,
    output display_value,
    output running,
    output tick,
    output overflow,
    output lap_active
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: STOPPED/RUNNING state machine, clk-to-tick prescaler and the
// 32-bit elapsed counter with load > clear > start/stop > count arbitration.
// Optional lap freeze of display_value is built when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned TICK_HZ  = 100
) (
  input logic             clk,
  input logic             resetn,
  stopwatch_ctrl_if.slave sw
);

  localparam int unsigned DIV = CLK_FREQ / TICK_HZ;
  localparam int unsigned PCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CW  = 32;

  localparam logic [PCW-1:0] PC_LAST = PCW'(DIV - 1);
  localparam logic [CW-1:0]  CNT_MAX = {CW{1'b1}};

  localparam logic [0:0] STOPPED = 1'b0;
  localparam logic [0:0] RUNNING = 1'b1;

  logic [0:0]     state_q,    state_d;
  logic [PCW-1:0] pcount_q,   pcount_d;
  logic [CW-1:0]  elapsed_q,  elapsed_d;
  logic           tick_q,     tick_d;
  logic           overflow_q, overflow_d;
  logic           terminal_c;

`ifdef STOPWATCH_LAP_EN
  logic           lap_active_q, lap_active_d;
  logic [CW-1:0]  lap_value_q,  lap_value_d;
`else
  logic           unused_btn_lap;
`endif

  // Prescaler wrap point; only meaningful while running
  assign terminal_c = (state_q == RUNNING) && (pcount_q == PC_LAST);

  // Next-state: load beats clear beats start/stop and counting
  always_comb begin
    state_d    = state_q;
    pcount_d   = pcount_q;
    elapsed_d  = elapsed_q;
    tick_d     = 1'b0;
    overflow_d = overflow_q;
`ifdef STOPWATCH_LAP_EN
    lap_active_d = lap_active_q;
    lap_value_d  = lap_value_q;
`endif

    if (sw.latch_test_value) begin
      elapsed_d  = sw.test_value;
      pcount_d   = '0;
      overflow_d = 1'b0;
`ifdef STOPWATCH_LAP_EN
      lap_active_d = 1'b0;
`endif
      // A start/stop arriving with the load still toggles the run state
      if (sw.btn_start_stop) begin
        state_d = ~state_q;
      end
    end else if (sw.btn_clear) begin
      elapsed_d  = '0;
      pcount_d   = '0;
      overflow_d = 1'b0;
      state_d    = STOPPED;
`ifdef STOPWATCH_LAP_EN
      lap_active_d = 1'b0;
`endif
    end else begin
      if (terminal_c) begin
        // Terminal count increments even when a stop arrives in the same cycle
        pcount_d  = '0;
        elapsed_d = elapsed_q + CW'(1);
        tick_d    = 1'b1;
        if (elapsed_q == CNT_MAX) begin
          overflow_d = 1'b1;
        end
      end else if ((state_q == RUNNING) && !sw.btn_start_stop) begin
        // The stop edge itself holds the prescaler so a pause keeps the fraction
        pcount_d = pcount_q + PCW'(1);
      end

      if (sw.btn_start_stop) begin
        state_d = ~state_q;
      end

`ifdef STOPWATCH_LAP_EN
      // Lap toggles: release from any state, capture only while running
      if (sw.btn_lap) begin
        if (lap_active_q) begin
          lap_active_d = 1'b0;
        end else if (state_q == RUNNING) begin
          lap_active_d = 1'b1;
          lap_value_d  = elapsed_d;
        end
      end
`endif
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= STOPPED;
      pcount_q   <= '0;
      elapsed_q  <= '0;
      tick_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcount_q   <= pcount_d;
      elapsed_q  <= elapsed_d;
      tick_q     <= tick_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  // Lap flag and frozen display value
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lap_active_q <= 1'b0;
      lap_value_q  <= '0;
    end else begin
      lap_active_q <= lap_active_d;
      lap_value_q  <= lap_value_d;
    end
  end

  assign sw.lap_active    = lap_active_q;
  assign sw.display_value = lap_active_q ? lap_value_q : elapsed_q;
`else
  assign unused_btn_lap   = sw.btn_lap;
  assign sw.lap_active    = 1'b0;
  assign sw.display_value = elapsed_q;
`endif

  assign sw.elapsed  = elapsed_q;
  assign sw.running  = (state_q == RUNNING);
  assign sw.tick     = tick_q;
  assign sw.overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed sequence with an expectation scoreboard,
// DIV = 1000/100 = 10. Lap expectations follow STOPWATCH_LAP_EN.
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_ON = 1'b1;
`else
  localparam bit LAP_ON = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [31:0] el;
    logic [31:0] dv;
    logic        run;
    logic        tk;
    logic        ov;
    logic        lap;
  } exp_t;

  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_fail;
  int   tick_cnt;
  exp_t sb[$];

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(
    .CLK_FREQ(1000),
    .TICK_HZ (100)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .sw    (sw_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges and settle just past the last one
  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present inputs for exactly one sampling edge
  task automatic apply(input logic ss, input logic clr, input logic lap,
                       input logic ld, input logic [31:0] tv);
    sw_if.btn_start_stop   = ss;
    sw_if.btn_clear        = clr;
    sw_if.btn_lap          = lap;
    sw_if.latch_test_value = ld;
    sw_if.test_value       = tv;
    adv(1);
    sw_if.btn_start_stop   = 1'b0;
    sw_if.btn_clear        = 1'b0;
    sw_if.btn_lap          = 1'b0;
    sw_if.latch_test_value = 1'b0;
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic exp_push(input string tag, input logic [31:0] el, input logic [31:0] dv,
                          input logic run, input logic tk, input logic ov, input logic lap);
    exp_t e;
    e.tag = tag; e.el = el; e.dv = dv; e.run = run; e.tk = tk; e.ov = ov; e.lap = lap;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL scoreboard_underflow: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      cmp({e.tag, ".elapsed"},       sw_if.elapsed,                e.el);
      cmp({e.tag, ".display_value"}, sw_if.display_value,          e.dv);
      cmp({e.tag, ".running"},       32'(sw_if.running),           32'(e.run));
      cmp({e.tag, ".tick"},          32'(sw_if.tick),              32'(e.tk));
      cmp({e.tag, ".overflow"},      32'(sw_if.overflow),          32'(e.ov));
      cmp({e.tag, ".lap_active"},    32'(sw_if.lap_active),        32'(e.lap));
    end
  endtask

  // Count tick pulses over n edges
  task automatic tick_window(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (sw_if.tick === 1'b1) cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    resetn = 1'b0;
    sw_if.btn_start_stop   = 1'b0;
    sw_if.btn_clear        = 1'b0;
    sw_if.btn_lap          = 1'b0;
    sw_if.latch_test_value = 1'b0;
    sw_if.test_value       = 32'h0;

    // Reset state
    exp_push("reset", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    adv(3);
    check_pop();
    resetn = 1'b1;
    adv(2);

    // Start and count: ticks at S+10, S+20, S+30
    exp_push("start", 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check_pop();
    exp_push("pre_tick1", 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    adv(9);
    check_pop();
    exp_push("tick1", 32'd1, 32'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    adv(1);
    check_pop();
    exp_push("tick1_end", 32'd1, 32'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    adv(1);
    check_pop();
    exp_push("tick2", 32'd2, 32'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    adv(9);
    check_pop();
    exp_push("tick3", 32'd3, 32'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    adv(10);
    check_pop();
    exp_push("count7", 32'd7, 32'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    adv(40);
    check_pop();

    // Clear beats start
    exp_push("clear_beats_start", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check_pop();

    // Pause at pcount 4, resume 25 edges later, next tick 6 edges after resume
    exp_push("start2", 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check_pop();
    exp_push("p_tick1", 32'd1, 32'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    adv(10);
    check_pop();
    exp_push("p_before_stop", 32'd1, 32'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    adv(4);
    check_pop();
    exp_push("stop", 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check_pop();
    exp_push("stopped_hold", 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick_window(24, tick_cnt);
    cmp("stopped_no_tick", 32'(tick_cnt), 32'd0);
    check_pop();
    exp_push("resume", 32'd1, 32'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check_pop();
    exp_push("resume_pre", 32'd1, 32'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    adv(5);
    check_pop();
    exp_push("resume_tick", 32'd2, 32'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    adv(1);
    check_pop();

    // Load plus start while stopped, then wrap and overflow
    exp_push("stop2", 32'd2, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check_pop();
    exp_push("load_start", 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    check_pop();
    exp_push("load_p10", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    adv(10);
    check_pop();
    exp_push("wrap", 32'd0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    adv(10);
    check_pop();
    exp_push("ovf_sticky", 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    adv(3);
    check_pop();
    exp_push("load5", 32'd5, 32'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 1'b1, 32'd5);
    check_pop();
    exp_push("load5_tick", 32'd6, 32'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    adv(10);
    check_pop();

    // Lap freeze and release
    exp_push("load3", 32'd3, 32'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 1'b1, 32'd3);
    check_pop();
    exp_push("el4", 32'd4, 32'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    adv(10);
    check_pop();
    exp_push("lap_on", 32'd4, 32'd4, 1'b1, 1'b0, 1'b0, LAP_ON);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    check_pop();
    exp_push("lap_el5", 32'd5, LAP_ON ? 32'd4 : 32'd5, 1'b1, 1'b1, 1'b0, LAP_ON);
    adv(9);
    check_pop();
    exp_push("lap_el6", 32'd6, LAP_ON ? 32'd4 : 32'd6, 1'b1, 1'b1, 1'b0, LAP_ON);
    adv(10);
    check_pop();
    exp_push("lap_off", 32'd6, 32'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    check_pop();

    // Reset on the edge where the prescaler would have wrapped
    exp_push("pre_reset", 32'd6, 32'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    adv(8);
    check_pop();
    resetn = 1'b0;
    exp_push("reset_mid", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    adv(1);
    check_pop();
    resetn = 1'b1;
    exp_push("post_reset", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick_window(12, tick_cnt);
    cmp("post_reset_no_tick", 32'(tick_cnt), 32'd0);
    check_pop();

    cmp("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
